// File: rtl/spi_pkg.sv
// Shared state encoding and bus constants for the byte-oriented SPI initiator.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;

  localparam logic SCK_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period timer: down-counter that ticks for one clk every CLK_DIV enabled cycles.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  // zero means "reload"; the sequence 0, CLK_DIV-1 .. 1 gives exactly CLK_DIV cycles per tick
  assign tick = en && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= CW'(CLK_DIV - 1);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_byte.sv
// SPI initiator (SCK idles high, MOSI on falling edge, MISO on rising edge, MSB first).
// Optional burst mode keeping csn low between same-target words: SPI_MASTER_CS_HOLD_EN.
//
// state | meaning
// IDLE  | tx_ready high, waiting for a word
// SETUP | csn asserted, SCK high for CLK_DIV cycles
// SHIFT | SCK toggling, DATA_WIDTH full periods
// HOLD  | rx_valid issued, csn still low for CLK_DIV cycles
// GAP   | csn high for CLK_DIV cycles before the next word
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int NUM_CS     = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            tx_valid,
  output logic                                            tx_ready,
  input  logic [DATA_WIDTH-1:0]                           tx_data,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] tx_cs,
  output logic                                            rx_valid,
  output logic [DATA_WIDTH-1:0]                           rx_data,
  output logic                                            busy,
  output logic                                            SCK,
  output logic                                            MOSI,
  input  logic                                            MISO,
  output logic [NUM_CS-1:0]                               csn
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_master_byte: CLK_DIV must be >= 2");
    end
  endgenerate

  spi_state_t            state, state_nxt;
  logic                  tick;
  logic                  accept, burst;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
  logic [NUM_CS-1:0]     cs_dec;
`ifdef SPI_MASTER_CS_HOLD_EN
  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_q;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick)
  );

  assign busy = (state != IDLE);

  // an out-of-range index selects nothing, yet the transfer still runs
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_dec[i] = (int'(tx_cs) != i);
    end
  end

  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    accept    = 1'b0;
    burst     = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && !SCK && bit_cnt == BCW'(DATA_WIDTH - 1)) state_nxt = HOLD;
      HOLD: begin
        if (tick) begin
          state_nxt = GAP;
`ifdef SPI_MASTER_CS_HOLD_EN
          tx_ready = 1'b1;
          if (tx_valid && tx_cs == cs_q) begin
            burst     = 1'b1;
            state_nxt = SHIFT;
          end
`endif
        end
      end
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      SCK      <= SCK_IDLE;
      MOSI     <= 1'b0;
      csn      <= '1;
`ifdef SPI_MASTER_CS_HOLD_EN
      cs_q     <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        tx_sh   <= tx_data;
        bit_cnt <= '0;
        csn     <= cs_dec;
`ifdef SPI_MASTER_CS_HOLD_EN
        cs_q    <= tx_cs;
`endif
      end
      if (burst) begin
        tx_sh   <= tx_data;
        bit_cnt <= '0;
      end
      if (state == SHIFT && tick) begin
        if (SCK) begin
          SCK   <= 1'b0;
          MOSI  <= tx_sh[DATA_WIDTH-1];
          tx_sh <= tx_sh << 1;
        end else begin
          SCK     <= 1'b1;
          rx_sh   <= DATA_WIDTH'({rx_sh, MISO});
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end
      // first HOLD cycle: the last rising edge has just shifted in the final bit
      if (state == HOLD && bit_cnt == BCW'(DATA_WIDTH)) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
        bit_cnt  <= '0;
      end
      if (state == HOLD && tick && !burst) begin
        csn <= '1;
      end
    end
  end

endmodule
